// File: rtl/ads131_pkg.sv
// ads131_pkg: shared opcodes, register addresses, table length, FSM states and entry types for the ADS131E08 config sequencer
// Optional build macro: ADS131_CFG_RESET_EN adds the RESET opcode and lengthens the table by one byte.
package ads131_pkg;
    localparam logic [7:0] CMD_START   = 8'h08;
    localparam logic [7:0] CMD_RDATAC  = 8'h10;
    localparam logic [7:0] CMD_SDATAC  = 8'h11;
    localparam logic [7:0] CMD_WREG    = 8'h40;
    localparam logic [7:0] REG_CONFIG1 = 8'h01;
    localparam logic [7:0] REG_CH1SET  = 8'h05;
`ifdef ADS131_CFG_RESET_EN
    localparam logic [7:0] CMD_RESET   = 8'h06;
    localparam logic [4:0] TABLE_LEN   = 5'd19;
`else
    localparam logic [4:0] TABLE_LEN   = 5'd18;
`endif
    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_TAIL, ST_GAP, ST_DONE} state_t;
    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } cmd_entry_t;
    typedef struct packed {
        logic [7:0] c1;
        logic [7:0] c2;
        logic [7:0] c3;
        logic [7:0] ch;
    } cfg_t;
    function automatic cmd_entry_t mk_entry(input logic last, input logic [7:0] data);
        cmd_entry_t e;
        e.last = last;
        e.data = data;
        return e;
    endfunction
endpackage

// File: rtl/ads131_cmd_rom.sv
// ads131_cmd_rom: maps a byte index and latched config to the {last_in_frame, byte} command table entry
// Ports: I_idx (5b byte index), I_cfg (latched CONFIG1-3/CHnSET values), O_entry ({last, byte}).
// Optional build macro: ADS131_CFG_RESET_EN prepends a single-byte RESET frame at index 0.
module ads131_cmd_rom
    import ads131_pkg::*;
(
    input  logic [4:0] I_idx,
    input  cfg_t       I_cfg,
    output cmd_entry_t O_entry
);
    logic [4:0] i;
    always_comb begin
`ifdef ADS131_CFG_RESET_EN
        i = I_idx - 5'd1;
`else
        i = I_idx;
`endif
        case (i)
            5'd0:                                       O_entry = mk_entry(1'b1, CMD_SDATAC);
            5'd1:                                       O_entry = mk_entry(1'b0, CMD_WREG | REG_CONFIG1);
            5'd2:                                       O_entry = mk_entry(1'b0, 8'd2);
            5'd3:                                       O_entry = mk_entry(1'b0, I_cfg.c1);
            5'd4:                                       O_entry = mk_entry(1'b0, I_cfg.c2);
            5'd5:                                       O_entry = mk_entry(1'b1, I_cfg.c3);
            5'd6:                                       O_entry = mk_entry(1'b0, CMD_WREG | REG_CH1SET);
            5'd7:                                       O_entry = mk_entry(1'b0, 8'd7);
            5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14: O_entry = mk_entry(1'b0, I_cfg.ch);
            5'd15:                                      O_entry = mk_entry(1'b1, I_cfg.ch);
            5'd16:                                      O_entry = mk_entry(1'b1, CMD_START);
            5'd17:                                      O_entry = mk_entry(1'b1, CMD_RDATAC);
            default:                                    O_entry = mk_entry(1'b0, 8'h00);
        endcase
`ifdef ADS131_CFG_RESET_EN
        if (I_idx == 5'd0) O_entry = mk_entry(1'b1, CMD_RESET);
`endif
    end
endmodule

// File: rtl/ads131_cfg_seq.sv
// ads131_cfg_seq: power-up configuration sequencer feeding the ADS131E08 byte-level SPI writer
// Ports: I_clk/I_rst_n (sync active-low reset), I_start (begin when idle), I_config1-3/I_chset (latched on start),
//        I_tx_done (writer byte-done pulse), O_tx_en/O_tx_data (writer enable and byte), O_busy, O_cfg_done (1-cycle).
// Optional build macro: ADS131_CFG_RESET_EN sends a RESET frame first, then idles RESET_WAIT clocks.
module ads131_cfg_seq
    import ads131_pkg::*;
#(
    parameter int GAP_CYCLES = 16
`ifdef ADS131_CFG_RESET_EN
    ,
    parameter int RESET_WAIT = 1024
`endif
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_start,
    input  logic [7:0] I_config1,
    input  logic [7:0] I_config2,
    input  logic [7:0] I_config3,
    input  logic [7:0] I_chset,
    input  logic       I_tx_done,
    output logic       O_tx_en,
    output logic [7:0] O_tx_data,
    output logic       O_busy,
    output logic       O_cfg_done
);
    state_t     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [7:0] gap_q, gap_d;
    cfg_t       cfg_q, cfg_d;
    cmd_entry_t entry_q, entry_d, rom_entry;
    logic       tx_en_q, tx_en_d;
    logic       busy_q, busy_d;
    logic       cfg_done_q, cfg_done_d;
    logic       wait_over;
    logic       start_ok;
    logic       adv;
    assign start_ok = state_q == ST_IDLE && I_start;
    assign adv      = state_q == ST_SEND && I_tx_done;
    // The ROM is addressed by the next index so the following byte is ready on the same edge as the done pulse.
    ads131_cmd_rom u_rom (
        .I_idx   (idx_d),
        .I_cfg   (cfg_q),
        .O_entry (rom_entry)
    );
`ifdef ADS131_CFG_RESET_EN
    localparam int RW_W = $clog2(RESET_WAIT) + 1;
    logic [RW_W-1:0] rw_q, rw_d;
    always_comb rw_d = state_q == ST_TAIL ? RW_W'(RESET_WAIT - 1) :
                       (state_q == ST_GAP && rw_q != '0) ? rw_q - 1'b1 : rw_q;
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) rw_q <= '0;
        else          rw_q <= rw_d;
    end
    // Index 1 means only the RESET frame has gone out, so the long settle wait applies.
    assign wait_over = idx_q == 5'd1 ? rw_q == '0 : gap_q == '0;
`else
    assign wait_over = gap_q == '0;
`endif
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            gap_q      <= '0;
            cfg_q      <= '0;
            entry_q    <= '0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            cfg_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            cfg_q      <= cfg_d;
            entry_q    <= entry_d;
            tx_en_q    <= tx_en_d;
            busy_q     <= busy_d;
            cfg_done_q <= cfg_done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = I_start ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: state_d = (I_tx_done && entry_q.last) ? ST_TAIL : ST_SEND;
            ST_TAIL: state_d = ST_GAP;
            ST_GAP:  state_d = !wait_over ? ST_GAP : idx_q == TABLE_LEN ? ST_DONE : ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end
    // TAIL keeps tx_en high one extra cycle so the writer completes bit0 without starting another byte.
    always_comb begin
        idx_d      = start_ok ? 5'd0 : adv ? idx_q + 5'd1 : idx_q;
        cfg_d      = start_ok ? '{c1: I_config1, c2: I_config2, c3: I_config3, ch: I_chset} : cfg_q;
        gap_d      = state_q == ST_TAIL ? 8'(GAP_CYCLES - 1) :
                     (state_q == ST_GAP && gap_q != '0) ? gap_q - 8'd1 : gap_q;
        entry_d    = (state_q == ST_LOAD || (adv && !entry_q.last)) ? rom_entry : entry_q;
        tx_en_d    = state_q == ST_LOAD ? 1'b1 : state_q == ST_TAIL ? 1'b0 : tx_en_q;
        busy_d     = start_ok ? 1'b1 : state_q == ST_DONE ? 1'b0 : busy_q;
        cfg_done_d = state_q == ST_DONE;
    end
    assign O_tx_en    = tx_en_q;
    assign O_tx_data  = entry_q.data;
    assign O_busy     = busy_q;
    assign O_cfg_done = cfg_done_q;
endmodule
